// File: rtl/sm_para_pkg.sv
// Shared encodings for the sm_para_2_fsm sequencing controller: state codes,
// status-flag patterns and the Moore output decode.
package sm_para_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t S1    = 2'd1;
    localparam state_t S2    = 2'd2;
    localparam state_t ERROR = 2'd3;

    typedef struct packed {
        logic o1;
        logic o2;
        logic err;
    } flags_t;

    localparam flags_t OUT_IDLE  = 3'b000;
    localparam flags_t OUT_S1    = 3'b100;
    localparam flags_t OUT_S2    = 3'b010;
    localparam flags_t OUT_ERROR = 3'b111;

    // Unknown or unreachable codes decode like IDLE so the flags stay quiet during recovery.
    function automatic flags_t decode_state(input state_t s);
        flags_t f;
        case (s)
            IDLE:    f = OUT_IDLE;
            S1:      f = OUT_S1;
            S2:      f = OUT_S2;
            ERROR:   f = OUT_ERROR;
            default: f = OUT_IDLE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sm_para_2_fsm.sv
// Four-state Moore controller tracking the IDLE->S1->S2->IDLE handshake on i1/i2
// and trapping illegal combinations in ERROR; status flags are registered.
//
// state | meaning
// IDLE  | waiting for i1&i2 to start a sequence
// S1    | first phase seen, waiting for i2 to rise with i1 held
// S2    | second phase, waiting for i2 to drop with i1 held
// ERROR | illegal combination seen, held until i1 drops
module sm_para_2_fsm
    import sm_para_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic i1,
    input  logic i2,
    output logic o1,
    output logic o2,
    output logic err
);

    state_t state_q, state_d;
    flags_t flags_q, flags_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (!i1)     state_d = IDLE;
                else if (i2) state_d = S1;
                else         state_d = ERROR;
            end
            S1: begin
                if (!i2)     state_d = S1;
                else if (i1) state_d = S2;
                else         state_d = ERROR;
            end
            S2: begin
                if (i2)      state_d = S2;
                else if (i1) state_d = IDLE;
                else         state_d = ERROR;
            end
            ERROR: begin
                if (i1)      state_d = ERROR;
                else         state_d = IDLE;
            end
            default:         state_d = IDLE;
        endcase
        // Flags are loaded alongside the state so they always match the current state.
        flags_d = decode_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            flags_q <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign o1  = flags_q.o1;
    assign o2  = flags_q.o2;
    assign err = flags_q.err;

endmodule

// File: tb/tb_sm_para_2_fsm.sv
// Scenario bench for sm_para_2_fsm: each vector pushes its expected flags to a
// scoreboard queue, which is popped and compared after the clock edge.
module tb_sm_para_2_fsm;

    logic clk;
    logic nrst;
    logic i1;
    logic i2;
    logic o1;
    logic o2;
    logic err;

    int vectors;
    int miscompares;
    logic [2:0] exp_q [$];

    sm_para_2_fsm dut (
        .clk (clk),
        .nrst(nrst),
        .i1  (i1),
        .i2  (i2),
        .o1  (o1),
        .o2  (o2),
        .err (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one vector {nrst,i1,i2} away from the edge, queue its expected flags,
    // then advance past the rising edge.
    task automatic drive(input logic [2:0] stim, input logic [2:0] exp_flags);
        @(negedge clk);
        nrst = stim[2];
        i1   = stim[1];
        i2   = stim[0];
        exp_q.push_back(exp_flags);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        logic [2:0] exp_v;
        drive(3'b011, 3'b000);
        got = {o1, o2, err};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL reset: scoreboard empty, got %b", got);
        end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset: got %b want %b", got, exp_v);
            end
        end
    endtask

    task automatic test_legal_loop();
        logic [5:0] tbl [3] = '{6'b111_100, 6'b111_010, 6'b110_000};
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL legal_loop[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_idle_hold();
        logic [5:0] tbl [3] = '{6'b100_000, 6'b101_000, 6'b100_000};
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL idle_hold[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_errors();
        // IDLE+(1,0); S1+(0,1); S2+(0,0), each recovered through i1=0.
        logic [5:0] tbl [9] = '{
            6'b110_111, 6'b100_000,
            6'b111_100, 6'b101_111, 6'b100_000,
            6'b111_100, 6'b111_010, 6'b100_111, 6'b100_000
        };
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL errors[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_error_recovery();
        logic [5:0] tbl [4] = '{6'b110_111, 6'b110_111, 6'b111_111, 6'b101_000};
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL error_recovery[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_holds();
        // S1 holds while i2=0 regardless of i1; S2 holds while i2=1 regardless of i1.
        logic [5:0] tbl [7] = '{
            6'b111_100, 6'b100_100, 6'b110_100,
            6'b111_010, 6'b111_010, 6'b101_010, 6'b110_000
        };
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL holds[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Reset from S2, then from ERROR, then from S1; each lands in IDLE.
        logic [5:0] tbl [9] = '{
            6'b111_100, 6'b111_010, 6'b011_000, 6'b100_000,
            6'b110_111, 6'b011_000, 6'b111_100, 6'b000_000, 6'b100_000
        };
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Two full legal loops with no idle cycle between them.
        logic [5:0] tbl [6] = '{
            6'b111_100, 6'b111_010, 6'b110_000,
            6'b111_100, 6'b111_010, 6'b110_000
        };
        logic [2:0] got;
        logic [2:0] exp_v;
        for (int k = 0; k < 6; k++) begin
            drive(tbl[k][5:3], tbl[k][2:0]);
            got = {o1, o2, err};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %b want %b", k, got, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst = 1'b0;
        i1   = 1'b0;
        i2   = 1'b0;
        test_reset();
        test_legal_loop();
        test_idle_hold();
        test_errors();
        test_error_recovery();
        test_holds();
        test_reset_mid();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
